// File: rtl/rca_bist_pkg.sv
// rca_bist_pkg: shared FSM encoding and sizing helpers for the ripple carry adder BIST checker
package rca_bist_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_t;

    function automatic int vec_w(input int width);
        return 2 * width + 1;
    endfunction

    function automatic int settle_w(input int settle);
        return $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/rca_golden_ref.sv
// rca_golden_ref: behavioural a+b+cin reference producing {cout,sum} for the checker
module rca_golden_ref #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/rca_bist_checker.sv
// rca_bist_checker: exhaustive (a,b,cin) sweep and check of an adder; RCA_BIST_STOP_ON_FAIL_EN ends a run at its first mismatch
module rca_bist_checker
    import rca_bist_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2,
    parameter int ERR_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   dut_a,
    output logic [WIDTH-1:0]   dut_b,
    output logic               dut_cin,
    input  logic [WIDTH-1:0]   dut_sum,
    input  logic               dut_cout,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [2*WIDTH:0]   first_fail_vec,
    output logic               first_fail_valid
);

    localparam int VW = vec_w(WIDTH);
    localparam int SW = settle_w(SETTLE);

    state_t          state, state_nx;
    logic [VW-1:0]   vec;
    logic [SW-1:0]   cnt;
    logic [WIDTH-1:0] gold_sum;
    logic            gold_cout;
    logic            mismatch, settled, last, stop, launch;

    rca_golden_ref #(.WIDTH(WIDTH)) u_gold (
        .a    (dut_a),
        .b    (dut_b),
        .cin  (dut_cin),
        .sum  (gold_sum),
        .cout (gold_cout)
    );

    assign {dut_cin, dut_b, dut_a} = vec;
    assign mismatch = (state == ST_CHECK) && ({dut_cout, dut_sum} != {gold_cout, gold_sum});
    assign settled  = cnt == SW'(SETTLE - 1);
    assign last     = &vec;
    assign launch   = start && (state == ST_IDLE || state == ST_DONE);
    assign busy     = state == ST_SETTLE || state == ST_CHECK;
    assign done     = state == ST_DONE;
    assign pass     = done && err_count == '0;

`ifdef RCA_BIST_STOP_ON_FAIL_EN
    assign stop = last || mismatch;
`else
    assign stop = last;
`endif

    // state register
    always_ff @(posedge clk)
        state <= rst ? ST_IDLE : state_nx;

    // next state: start only acts when idle or done, sweep ends on the last vector
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   state_nx = start ? ST_SETTLE : ST_IDLE;
            ST_SETTLE: state_nx = settled ? ST_CHECK : ST_SETTLE;
            ST_CHECK:  state_nx = stop ? ST_DONE : ST_SETTLE;
            ST_DONE:   state_nx = start ? ST_SETTLE : ST_DONE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // vector sweep, settle timing, saturating error count and first-failure capture
    always_ff @(posedge clk) begin
        if (rst || launch) begin
            vec              <= '0;
            cnt              <= '0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else if (state == ST_SETTLE) begin
            cnt <= settled ? '0 : cnt + 1'b1;
        end else if (state == ST_CHECK) begin
            if (mismatch) begin
                err_count <= &err_count ? err_count : err_count + 1'b1;
                if (!first_fail_valid) begin
                    first_fail_vec   <= vec;
                    first_fail_valid <= 1'b1;
                end
            end
            if (!stop)
                vec <= vec + 1'b1;
        end
    end

endmodule

// File: tb/tb_rca_bist_checker.sv
// tb_rca_bist_checker: randomized fault-injection bench for the adder BIST checker against a sweep-level model
module tb_rca_bist_checker;

    localparam int W  = 4;
    localparam int S  = 2;
    localparam int NV = 1 << (2 * W + 1);

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [W-1:0] a0, b0, s0, a1, b1, s1;
    logic c0, co0, c1, co1;
    logic busy0, done0, pass0, busy1, done1, pass1;
    logic [15:0] err0;
    logic [3:0] err1;
    logic [2*W:0] ffv0, ffv1, tgt = '0;
    logic ffok0, ffok1;
    int mode = 0, fbit = 0;
    int n_checks = 0, n_fail = 0;
    int exp_err, exp_n, exp_first, exp_valid;

    always #5 clk = ~clk;

    // adder under test with an optional injected fault
    function automatic logic [W:0] adder(input logic [2*W:0] v, input int md, input int fb, input logic [2*W:0] tv);
        logic [W:0] r;
        r = (W+1)'(v[W-1:0]) + (W+1)'(v[2*W-1:W]) + (W+1)'(v[2*W]);
        if (md == 1) r[W] = 1'b0;
        if (md == 2) r[0] = ~r[0];
        if (md == 3 && v == tv) r[fb] = ~r[fb];
        return r;
    endfunction

    always_comb {co0, s0} = adder({c0, b0, a0}, mode, fbit, tgt);
    always_comb {co1, s1} = adder({c1, b1, a1}, mode, fbit, tgt);

    rca_bist_checker #(.WIDTH(W), .SETTLE(S), .ERR_W(16)) u0 (
        .clk(clk), .rst(rst), .start(start),
        .dut_a(a0), .dut_b(b0), .dut_cin(c0), .dut_sum(s0), .dut_cout(co0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_vec(ffv0), .first_fail_valid(ffok0)
    );

    rca_bist_checker #(.WIDTH(W), .SETTLE(S), .ERR_W(4)) u1 (
        .clk(clk), .rst(rst), .start(start),
        .dut_a(a1), .dut_b(b1), .dut_cin(c1), .dut_sum(s1), .dut_cout(co1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_vec(ffv1), .first_fail_valid(ffok1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // expected outcome of one sweep from plain integer arithmetic
    task automatic model();
        exp_err = 0; exp_n = NV; exp_first = 0; exp_valid = 0;
        for (int v = 0; v < NV; v++) begin
            int a, b, c;
            a = v % (1 << W);
            b = (v / (1 << W)) % (1 << W);
            c = v / (1 << (2 * W));
            if (int'(adder((2*W+1)'(v), mode, fbit, tgt)) != a + b + c) begin
                if (exp_valid == 0) begin
                    exp_first = v;
                    exp_valid = 1;
                end
                exp_err++;
`ifdef RCA_BIST_STOP_ON_FAIL_EN
                exp_n = v + 1;
                break;
`endif
            end
        end
    endtask

    task automatic run(input string tag);
        int cyc;
        logic viol;
        model();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        check({tag, "_busy"}, busy0, 1);
        check({tag, "_done0"}, done0, 0);
        check({tag, "_pass0"}, pass0, 0);
        check({tag, "_vec0"}, {c0, b0, a0}, 0);
        check({tag, "_errclr"}, err0, 0);
        cyc = 0; viol = 1'b0;
        while (!done0 && cyc < NV * (S + 1) + 100) begin
            start = ($urandom_range(0, 199) == 0);
            @(posedge clk); #1; cyc++;
            viol |= (pass0 & busy0) | (pass1 & busy1);
        end
        start = 1'b0;
        check({tag, "_cycles"}, cyc, exp_n * (S + 1));
        check({tag, "_done1"}, done1, 1);
        check({tag, "_busy_end"}, busy0, 0);
        check({tag, "_err16"}, err0, exp_err > 65535 ? 65535 : exp_err);
        check({tag, "_err4"}, err1, exp_err > 15 ? 15 : exp_err);
        check({tag, "_ffv"}, ffv0, exp_first);
        check({tag, "_ffok"}, ffok0, exp_valid);
        check({tag, "_ffv4"}, ffv1, exp_first);
        check({tag, "_ffok4"}, ffok1, exp_valid);
        check({tag, "_pass"}, pass0, exp_err == 0);
        check({tag, "_pass4"}, pass1, exp_err == 0);
        check({tag, "_lastvec"}, {c0, b0, a0}, exp_n - 1);
        check({tag, "_pass_busy"}, viol, 0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_held"}, {done0, busy0, err0}, {1'b1, 1'b0, exp_err > 65535 ? 16'hffff : 16'(exp_err)});
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", {busy0, done0, pass0, err0, ffok0, ffv0, c0, b0, a0}, 0);
        @(negedge clk); rst = 1'b0;

        mode = 0; run("clean");
        mode = 1; run("cout0");
        mode = 2; run("sum0");

        mode = 1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat ($urandom_range(100, 400)) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst", {busy0, done0, pass0, err0, ffok0, ffv0, c0, b0, a0}, 0);
        check("midrst4", {busy1, done1, err1, ffok1}, 0);
        @(negedge clk); rst = 1'b0;
        mode = 0; run("after_rst");

        for (int i = 0; i < 2; i++) begin
            mode = 3;
            tgt  = (2*W+1)'($urandom_range(0, NV - 1));
            fbit = $urandom_range(0, W);
            run($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
